sync_serial_tx: RTL

- Transmit end of the team's single-wire synchronous serial link. The receive end is a chain of clocked data flops on the same clock.
- Accepts a parallel word over a valid/ready handshake, then shifts it out one bit per clock on ser_out, qualified by ser_frame.
- Optionally appends a parity bit, then holds the line idle for a programmable gap.

---
 rtl/sync_serial_pkg.sv | 18 +
 rtl/sync_serial_shreg.sv | 30 +++
 rtl/sync_serial_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sync_serial_pkg.sv
// Shared definitions for the single-wire synchronous serial link.
package sync_serial_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Parity bit from the XOR-reduction of a word; odd=1 inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/sync_serial_shreg.sv
// Loadable shift register presenting its head bit in the configured bit order.
module sync_serial_shreg
  import sync_serial_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              bit_out
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_data;
    end else if (shift) begin
      sr_q <= MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end
  end

  assign bit_out = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];

endmodule

// File: rtl/sync_serial_tx.sv
// Transmit end of the synchronous serial link: handshake in a word, shift it out
// with optional parity, then hold the line idle for a programmable gap.
module sync_serial_tx
  import sync_serial_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              tx_done,
  output logic              busy
);

  localparam int unsigned      CNT_W       = $clog2(DATA_W + 1);
  localparam int unsigned      GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_t           AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              parity_q, parity_d;
  logic              ser_out_d, ser_frame_d, tx_done_d;
  logic              sh_load, sh_shift, sh_bit;
  logic              first_bit;
  logic [DATA_W-1:0] load_word;

  // The first bit leaves straight from tx_data, so the register is loaded one step ahead.
  assign first_bit = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
  assign load_word = MSB_FIRST ? (tx_data << 1) : (tx_data >> 1);

  sync_serial_shreg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (load_word),
    .bit_out   (sh_bit)
  );

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    parity_d    = parity_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    ser_out_d   = IDLE_LEVEL;
    ser_frame_d = 1'b0;
    tx_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          parity_d  = parity_bit(^tx_data, PARITY_ODD);
          sh_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = PARITY_EN ? PARITY : AFTER_FRAME;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          sh_shift  = 1'b1;
        end
      end
      PARITY: begin
        state_d   = AFTER_FRAME;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line outputs are decoded from the next state so they stay in phase with it.
    case (state_d)
      SHIFT: begin
        ser_frame_d = 1'b1;
        ser_out_d   = (state_q == IDLE) ? first_bit : sh_bit;
        tx_done_d   = !PARITY_EN && (bit_cnt_d == LAST_BIT);
      end
      PARITY: begin
        ser_frame_d = 1'b1;
        ser_out_d   = parity_q;
        tx_done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      parity_q  <= 1'b0;
      ser_out   <= IDLE_LEVEL;
      ser_frame <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      parity_q  <= parity_d;
      ser_out   <= ser_out_d;
      ser_frame <= ser_frame_d;
      tx_done   <= tx_done_d;
    end
  end

endmodule
